// File: rtl/union_field_regbank.sv
// Bank of packed-union registers with whole-word and per-field write/read views and a 1-entry read output stage.
// Optional macro UNION_REGBANK_BYPASS_EN: a same-cycle read of the entry being written returns the post-write value.
module union_field_regbank #(
  parameter int unsigned FIELD_W = 4,
  parameter int unsigned NFIELDS = 2,
  parameter int unsigned DEPTH = 4,
  parameter logic [FIELD_W-1:0] INIT_FIELD = 4'hA,
  localparam int unsigned WORD_W = FIELD_W * NFIELDS,
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned FIW = (NFIELDS > 1) ? $clog2(NFIELDS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [AW-1:0]     wr_addr,
  input  logic              wr_view,
  input  logic [FIW-1:0]    wr_field,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              rq_valid,
  output logic              rq_ready,
  input  logic [AW-1:0]     rq_addr,
  input  logic              rq_whole,
  input  logic [FIW-1:0]    rq_field,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [WORD_W-1:0] rd_data
);

  typedef union packed {
    logic [WORD_W-1:0]                word;
    logic [NFIELDS-1:0][FIELD_W-1:0]  fields;
  } entry_t;

  localparam logic [AW:0]  DEPTH_L = (AW + 1)'(DEPTH);
  localparam logic [FIW:0] NFIELDS_L = (FIW + 1)'(NFIELDS);

  entry_t      mem [DEPTH];
  entry_t      wr_merged;
  entry_t      rd_src;
  logic [WORD_W-1:0] rd_next;
  logic        wr_fire;
  logic        wr_en;
  logic        wr_addr_ok;
  logic        wr_field_ok;
  logic        rq_fire;
  logic        rq_addr_ok;
  logic        rq_field_ok;

  assign wr_ready    = !rst;
  assign rq_ready    = !rst && (!rd_valid || rd_ready);
  assign wr_fire     = wr_valid && wr_ready;
  assign rq_fire     = rq_valid && rq_ready;
  assign wr_addr_ok  = {1'b0, wr_addr} < DEPTH_L;
  assign wr_field_ok = {1'b0, wr_field} < NFIELDS_L;
  assign rq_addr_ok  = {1'b0, rq_addr} < DEPTH_L;
  assign rq_field_ok = {1'b0, rq_field} < NFIELDS_L;
  // Out-of-range targets are accepted but leave storage untouched.
  assign wr_en       = wr_fire && wr_addr_ok && (!wr_view || wr_field_ok);

  // Post-write image of the addressed entry; a field write merges into the old word.
  always_comb begin
    wr_merged = '0;
    if (wr_addr_ok) begin
      wr_merged = mem[wr_addr];
    end
    if (!wr_view) begin
      wr_merged.word = wr_data;
    end else if (wr_field_ok) begin
      wr_merged.fields[wr_field] = wr_data[FIELD_W-1:0];
    end
  end

  // Storage update; independent of read backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= {NFIELDS{INIT_FIELD}};
      end
    end else if (wr_en) begin
      mem[wr_addr] <= wr_merged;
    end
  end

  // Read source word, then whole/field selection with zero extension.
  always_comb begin
    rd_src = '0;
    if (rq_addr_ok) begin
      rd_src = mem[rq_addr];
`ifdef UNION_REGBANK_BYPASS_EN
      if (wr_en && (wr_addr == rq_addr)) begin
        rd_src = wr_merged;
      end
`endif
    end
    rd_next = '0;
    if (rq_whole) begin
      rd_next = rd_src.word;
    end else if (rq_field_ok) begin
      rd_next = WORD_W'(rd_src.fields[rq_field]);
    end
  end

  // Single-entry output stage; data holds after the consumer drains it.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else if (rq_fire) begin
      rd_valid <= 1'b1;
      rd_data  <= rd_next;
    end else if (rd_ready) begin
      rd_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_union_field_regbank.sv
// Directed self-checking bench for union_field_regbank: default instance plus a 3-field, 3-entry instance for range checks.
module tb_union_field_regbank;

  logic clk;
  logic rst;

  logic       wr_valid, wr_ready, wr_view;
  logic [1:0] wr_addr;
  logic [0:0] wr_field;
  logic [7:0] wr_data;
  logic       rq_valid, rq_ready, rq_whole;
  logic [1:0] rq_addr;
  logic [0:0] rq_field;
  logic       rd_valid, rd_ready;
  logic [7:0] rd_data;

  logic        b_wr_valid, b_wr_ready, b_wr_view;
  logic [1:0]  b_wr_addr, b_wr_field;
  logic [11:0] b_wr_data;
  logic        b_rq_valid, b_rq_ready, b_rq_whole;
  logic [1:0]  b_rq_addr, b_rq_field;
  logic        b_rd_valid, b_rd_ready;
  logic [11:0] b_rd_data;

  int checks = 0;
  int failures = 0;

`ifdef UNION_REGBANK_BYPASS_EN
  localparam logic [7:0] EXP_SAME_WORD  = 8'h77;
  localparam logic [7:0] EXP_SAME_FIELD = 8'h09;
`else
  localparam logic [7:0] EXP_SAME_WORD  = 8'hAA;
  localparam logic [7:0] EXP_SAME_FIELD = 8'h0C;
`endif

  union_field_regbank dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_view(wr_view),
    .wr_field(wr_field), .wr_data(wr_data),
    .rq_valid(rq_valid), .rq_ready(rq_ready), .rq_addr(rq_addr), .rq_whole(rq_whole),
    .rq_field(rq_field),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data)
  );

  union_field_regbank #(.FIELD_W(4), .NFIELDS(3), .DEPTH(3), .INIT_FIELD(4'hA)) dut_b (
    .clk(clk), .rst(rst),
    .wr_valid(b_wr_valid), .wr_ready(b_wr_ready), .wr_addr(b_wr_addr), .wr_view(b_wr_view),
    .wr_field(b_wr_field), .wr_data(b_wr_data),
    .rq_valid(b_rq_valid), .rq_ready(b_rq_ready), .rq_addr(b_rq_addr), .rq_whole(b_rq_whole),
    .rq_field(b_rq_field),
    .rd_valid(b_rd_valid), .rd_ready(b_rd_ready), .rd_data(b_rd_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    wr_valid = 0; wr_addr = '0; wr_view = 0; wr_field = '0; wr_data = '0;
    rq_valid = 0; rq_addr = '0; rq_whole = 1; rq_field = '0; rd_ready = 1;
    b_wr_valid = 0; b_wr_addr = '0; b_wr_view = 0; b_wr_field = '0; b_wr_data = '0;
    b_rq_valid = 0; b_rq_addr = '0; b_rq_whole = 1; b_rq_field = '0; b_rd_ready = 1;
    step();
    step();
    chk("reset_rd_valid", 16'(rd_valid), 16'h0);
    chk("reset_rd_data", 16'(rd_data), 16'h0);
    chk("reset_wr_ready", 16'(wr_ready), 16'h0);
    chk("reset_rq_ready", 16'(rq_ready), 16'h0);

    rst = 1'b0;
    #1;
    chk("run_wr_ready", 16'(wr_ready), 16'h1);
    chk("run_rq_ready", 16'(rq_ready), 16'h1);

    // Back-to-back whole reads of the reset image
    for (int a = 0; a < 4; a++) begin
      rq_valid = 1; rq_whole = 1; rq_addr = 2'(a);
      step();
      chk($sformatf("init_valid_%0d", a), 16'(rd_valid), 16'h1);
      chk($sformatf("init_data_%0d", a), 16'(rd_data), 16'h00AA);
    end
    rq_valid = 0;
    step();
    chk("drain_valid", 16'(rd_valid), 16'h0);
    chk("drain_hold_data", 16'(rd_data), 16'h00AA);

    // Whole write, then field reads
    wr_valid = 1; wr_addr = 1; wr_view = 0; wr_data = 8'h3C;
    step();
    wr_valid = 0;
    rq_valid = 1; rq_addr = 1; rq_whole = 0; rq_field = 0;
    step();
    chk("e1_f0", 16'(rd_data), 16'h000C);
    rq_field = 1;
    step();
    chk("e1_f1", 16'(rd_data), 16'h0003);
    rq_valid = 0;
    step();

    // Field write uses only the low field bits
    wr_valid = 1; wr_addr = 2; wr_view = 1; wr_field = 1; wr_data = 8'hF5;
    step();
    wr_valid = 0;
    rq_valid = 1; rq_addr = 2; rq_whole = 1;
    step();
    chk("e2_whole", 16'(rd_data), 16'h005A);
    rq_valid = 0;
    step();

    // Backpressure with a queued request and a write that must not stall
    rd_ready = 0;
    rq_valid = 1; rq_addr = 1; rq_whole = 1;
    step();
    chk("bp_first_valid", 16'(rd_valid), 16'h1);
    chk("bp_first_data", 16'(rd_data), 16'h003C);
    rq_addr = 2;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("bp_rq_ready_%0d", i), 16'(rq_ready), 16'h0);
      if (i == 1) begin
        wr_valid = 1; wr_addr = 3; wr_view = 0; wr_data = 8'h96;
        chk("bp_wr_ready", 16'(wr_ready), 16'h1);
      end
      step();
      wr_valid = 0;
      chk($sformatf("bp_valid_%0d", i), 16'(rd_valid), 16'h1);
      chk($sformatf("bp_data_%0d", i), 16'(rd_data), 16'h003C);
    end
    rd_ready = 1;
    #1;
    chk("bp_release_rq_ready", 16'(rq_ready), 16'h1);
    step();
    chk("bp_queued_data", 16'(rd_data), 16'h005A);
    rq_addr = 3;
    step();
    chk("bp_write_landed", 16'(rd_data), 16'h0096);
    rq_valid = 0;
    step();
    chk("bp_drain_valid", 16'(rd_valid), 16'h0);

    // Same-cycle write and read of one entry
    wr_valid = 1; wr_addr = 0; wr_view = 0; wr_data = 8'h77;
    rq_valid = 1; rq_addr = 0; rq_whole = 1;
    step();
    wr_valid = 0;
    chk("same_word", 16'(rd_data), 16'(EXP_SAME_WORD));
    step();
    chk("after_word", 16'(rd_data), 16'h0077);
    wr_valid = 1; wr_addr = 1; wr_view = 1; wr_field = 0; wr_data = 8'h09;
    rq_addr = 1; rq_whole = 0; rq_field = 0;
    step();
    wr_valid = 0;
    chk("same_field", 16'(rd_data), 16'(EXP_SAME_FIELD));
    rq_whole = 1;
    step();
    chk("after_field", 16'(rd_data), 16'h0039);
    rq_valid = 0;
    step();

    // Reset with a pending response; write during reset is ignored
    rd_ready = 0;
    rq_valid = 1; rq_addr = 3; rq_whole = 1;
    step();
    chk("pre_rst_data", 16'(rd_data), 16'h0096);
    rst = 1; rq_valid = 0;
    wr_valid = 1; wr_addr = 0; wr_view = 0; wr_data = 8'h55;
    step();
    chk("rst_mid_valid", 16'(rd_valid), 16'h0);
    chk("rst_mid_data", 16'(rd_data), 16'h0);
    chk("rst_mid_wr_ready", 16'(wr_ready), 16'h0);
    chk("rst_mid_rq_ready", 16'(rq_ready), 16'h0);
    rst = 0; wr_valid = 0; rd_ready = 1;
    for (int a = 0; a < 4; a++) begin
      rq_valid = 1; rq_whole = 1; rq_addr = 2'(a);
      step();
      chk($sformatf("reinit_data_%0d", a), 16'(rd_data), 16'h00AA);
    end
    rq_valid = 0;
    step();

    // Range handling on the 3-field, 3-entry instance
    b_rq_valid = 1; b_rq_addr = 0; b_rq_whole = 0; b_rq_field = 2;
    step();
    chk("b_f2", 16'(b_rd_data), 16'h000A);
    b_rq_field = 3;
    step();
    chk("b_f3_valid", 16'(b_rd_valid), 16'h1);
    chk("b_f3_data", 16'(b_rd_data), 16'h0000);
    b_rq_addr = 3; b_rq_whole = 1;
    step();
    chk("b_addr3_valid", 16'(b_rd_valid), 16'h1);
    chk("b_addr3_data", 16'(b_rd_data), 16'h0000);
    b_rq_valid = 0;
    b_wr_valid = 1; b_wr_addr = 1; b_wr_view = 1; b_wr_field = 3; b_wr_data = 12'hFFF;
    step();
    b_wr_addr = 3; b_wr_view = 0; b_wr_data = 12'h123;
    step();
    b_wr_addr = 0; b_wr_view = 1; b_wr_field = 2; b_wr_data = 12'h005;
    step();
    b_wr_valid = 0;
    b_rq_valid = 1; b_rq_addr = 1; b_rq_whole = 1;
    step();
    chk("b_e1_untouched", 16'(b_rd_data), 16'h0AAA);
    b_rq_addr = 0;
    step();
    chk("b_e0_f2_write", 16'(b_rd_data), 16'h05AA);
    b_rq_addr = 2;
    step();
    chk("b_e2_untouched", 16'(b_rd_data), 16'h0AAA);
    b_rq_valid = 0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
